// File: rtl/dla_pkg.sv
// Shared definitions for the DLA control stage: sequencer states, wrapper
// register map, CFG field positions and config strobe bit indices.
package dla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [31:0] CFG0_ADDR   = 32'h6000_0000;
    localparam logic [31:0] CFG1_ADDR   = 32'h6000_0004;
    localparam logic [31:0] STATUS_ADDR = 32'h6000_0008;

    localparam int unsigned CFG0_LEN_LSB  = 0;
    localparam int unsigned CFG0_SEL_BIT  = 16;
    localparam int unsigned CFG0_RELU_BIT = 17;
    localparam int unsigned CFG1_IFM_LSB  = 0;
    localparam int unsigned CFG1_WGT_LSB  = 16;
    localparam int unsigned CMD_START_BIT = 0;
    localparam int unsigned CMD_CLR_BIT   = 1;

    localparam int unsigned WEN_CFG0 = 0;
    localparam int unsigned WEN_CFG1 = 1;
    localparam int unsigned WEN_CMD  = 2;

endpackage

// File: rtl/dla_mac4.sv
// Combinational 4-lane signed int8 multiply with adder tree; 18-bit signed sum.
module dla_mac4 (
    input  logic [31:0]        ifm_word,
    input  logic [31:0]        weight_word,
    output logic signed [17:0] sum
);

    logic signed [7:0]  lane_a;
    logic signed [7:0]  lane_b;
    logic signed [15:0] prod;

    always_comb begin
        sum    = '0;
        lane_a = '0;
        lane_b = '0;
        prod   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            lane_a = ifm_word[8*i +: 8];
            lane_b = weight_word[8*i +: 8];
            prod   = lane_a * lane_b;
            sum    = sum + 18'(prod);
        end
    end

endmodule

// File: rtl/dla_ctrl.sv
// DLA config registers and dot-product sequencer behind the AXI slave wrapper.
// Optional ReLU on the final result is built when DLA_CTRL_RELU_EN is defined.
module dla_ctrl
    import dla_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 15,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        config_w_en,
    input  logic [31:0]       w_data,
    output logic              ifm_sel,
    output logic [ADDR_W-1:0] ifm_r_addr,
    output logic [ADDR_W-1:0] weight_r_addr,
    output logic              sram_r_en,
    input  logic [31:0]       ifm_r_data,
    input  logic [31:0]       weight_r_data,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result
);

    state_t                   state;
    logic [LEN_W-1:0]         len;
    logic [LEN_W-1:0]         cnt;
    logic [ADDR_W-1:0]        ifm_base;
    logic [ADDR_W-1:0]        weight_base;
    logic                     relu;
    logic                     vld;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  final_val;
    logic signed [17:0]       mac_sum;
    logic                     cmd_start;
    logic                     cmd_clr;

    dla_mac4 u_mac4 (
        .ifm_word    (ifm_r_data),
        .weight_word (weight_r_data),
        .sum         (mac_sum)
    );

    assign cmd_start = config_w_en[WEN_CMD] & w_data[CMD_START_BIT];
    assign cmd_clr   = config_w_en[WEN_CMD] & w_data[CMD_CLR_BIT];

    // vld marks the cycle in which the word issued one cycle earlier is on the read bus
    always_comb begin
        acc_next = acc;
        if (vld)
            acc_next = acc + ACC_W'(mac_sum);
    end

`ifdef DLA_CTRL_RELU_EN
    always_comb begin
        final_val = acc_next;
        if (relu && acc_next[ACC_W-1])
            final_val = '0;
    end
    logic unused_bits;
    assign unused_bits = ^{w_data[31:30], w_data[15]};
`else
    always_comb final_val = acc_next;
    logic unused_bits;
    assign unused_bits = ^{w_data[31:30], w_data[15], relu};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            cnt           <= '0;
            ifm_base      <= '0;
            weight_base   <= '0;
            relu          <= 1'b0;
            ifm_sel       <= 1'b0;
            vld           <= 1'b0;
            acc           <= '0;
            ifm_r_addr    <= '0;
            weight_r_addr <= '0;
            sram_r_en     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= '0;
        end else begin
            vld <= sram_r_en;
            acc <= acc_next;

            if (!busy) begin
                if (config_w_en[WEN_CFG0]) begin
                    len     <= w_data[CFG0_LEN_LSB +: LEN_W];
                    ifm_sel <= w_data[CFG0_SEL_BIT];
                    relu    <= w_data[CFG0_RELU_BIT];
                end
                if (config_w_en[WEN_CFG1]) begin
                    ifm_base    <= w_data[CFG1_IFM_LSB +: ADDR_W];
                    weight_base <= w_data[CFG1_WGT_LSB +: ADDR_W];
                end
            end

            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (cmd_start) begin
                        acc  <= '0;
                        done <= 1'b0;
                        if (len == '0) begin
                            state  <= FIN;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            state         <= RUN;
                            busy          <= 1'b1;
                            sram_r_en     <= 1'b1;
                            ifm_r_addr    <= ifm_base;
                            weight_r_addr <= weight_base;
                            cnt           <= len;
                        end
                    end
                end
                RUN: begin
                    if (cnt == LEN_W'(1)) begin
                        state     <= DRAIN;
                        sram_r_en <= 1'b0;
                    end else begin
                        cnt           <= cnt - LEN_W'(1);
                        ifm_r_addr    <= ifm_r_addr + ADDR_W'(1);
                        weight_r_addr <= weight_r_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state  <= FIN;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= final_val;
                end
                default: state <= IDLE;
            endcase

            // a clear outranks both start and completion in the same cycle
            if (cmd_clr)
                done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dla_ctrl.sv
// Directed self-checking bench for dla_ctrl with an SRAM model and result/address scoreboard.
module tb_dla_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  config_w_en;
    logic [31:0] w_data;
    logic        ifm_sel;
    logic [13:0] ifm_r_addr;
    logic [13:0] weight_r_addr;
    logic        sram_r_en;
    logic [31:0] ifm_r_data;
    logic [31:0] weight_r_data;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    logic [31:0] ifm0 [0:16383];
    logic [31:0] ifm1 [0:16383];
    logic [31:0] wmem [0:16383];

    logic [13:0] ifm_q[$];
    logic [13:0] wgt_q[$];
    logic [31:0] res_q[$];

    always #5 clk = ~clk;

    dla_ctrl #(.ADDR_W(14), .LEN_W(15), .ACC_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .config_w_en   (config_w_en),
        .w_data        (w_data),
        .ifm_sel       (ifm_sel),
        .ifm_r_addr    (ifm_r_addr),
        .weight_r_addr (weight_r_addr),
        .sram_r_en     (sram_r_en),
        .ifm_r_data    (ifm_r_data),
        .weight_r_data (weight_r_data),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    // One-cycle read latency SRAM banks
    always @(posedge clk) begin
        if (sram_r_en) begin
            ifm_r_data    <= ifm_sel ? ifm1[ifm_r_addr] : ifm0[ifm_r_addr];
            weight_r_data <= wmem[weight_r_addr];
        end
    end

    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int s;
        logic signed [7:0] x;
        logic signed [7:0] y;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            x = a[8*i +: 8];
            y = b[8*i +: 8];
            s += int'(x) * int'(y);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input logic [31:0] data);
        config_w_en = 3'(1 << idx);
        w_data      = data;
        tick();
        config_w_en = '0;
        w_data      = '0;
    endtask

    // Issue CMD and follow the run cycle by cycle; disturb injects a start then a CFG0 write mid-run
    task automatic do_run(input logic [31:0] cmd, input int len, input logic [13:0] ib,
                          input logic [13:0] wb, input logic [31:0] exp, input bit disturb);
        for (int i = 0; i < len; i++) begin
            ifm_q.push_back(ib + 14'(i));
            wgt_q.push_back(wb + 14'(i));
        end
        res_q.push_back(exp);
        cfg_write(2, cmd);
        if (len == 0) begin
            chk("len0_done_c1", 32'(done), 32'd1);
            chk("len0_busy_c1", 32'(busy), 32'd0);
            chk("len0_ren_c1", 32'(sram_r_en), 32'd0);
            chk("len0_result", result, res_q.pop_front());
            tick();
            chk("len0_done_c2", 32'(done), 32'd1);
            chk("len0_ren_c2", 32'(sram_r_en), 32'd0);
            return;
        end
        for (int k = 1; k <= len + 1; k++) begin
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done_low", 32'(done), 32'd0);
            if (k <= len) begin
                chk("run_ren", 32'(sram_r_en), 32'd1);
                chk("ifm_addr", 32'(ifm_r_addr), 32'(ifm_q.pop_front()));
                chk("weight_addr", 32'(weight_r_addr), 32'(wgt_q.pop_front()));
            end else begin
                chk("drain_ren", 32'(sram_r_en), 32'd0);
            end
            config_w_en = '0;
            w_data      = '0;
            if (disturb && k == 2) begin
                config_w_en = 3'b100;
                w_data      = 32'd1;
            end
            if (disturb && k == 3) begin
                config_w_en = 3'b001;
                w_data      = 32'd1;
            end
            tick();
        end
        config_w_en = '0;
        w_data      = '0;
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_ren", 32'(sram_r_en), 32'd0);
        chk("fin_result", result, res_q.pop_front());
        tick();
    endtask

    initial begin
        logic [31:0] exp_wrap;
        logic [31:0] exp_relu;
        rst           = 1'b1;
        config_w_en   = '0;
        w_data        = '0;
        ifm_r_data    = '0;
        weight_r_data = '0;
        for (int i = 0; i < 16384; i++) begin
            ifm0[i] = '0;
            ifm1[i] = '0;
            wmem[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_ren", 32'(sram_r_en), 32'd0);
        chk("rst_ifm_addr", 32'(ifm_r_addr), 32'd0);
        chk("rst_wgt_addr", 32'(weight_r_addr), 32'd0);
        chk("rst_ifm_sel", 32'(ifm_sel), 32'd0);
        rst = 1'b0;
        tick();

        // Basic 4-word run: 4 words x (4 x 1*2) = 32
        for (int i = 0; i < 4; i++) begin
            ifm0[i] = 32'h0101_0101;
            wmem[i] = 32'h0202_0202;
        end
        cfg_write(0, 32'd4);
        cfg_write(1, 32'd0);
        do_run(32'd1, 4, 14'd0, 14'd0, 32'd32, 1'b0);

        // Signed lanes from IFM1 bank
        ifm1[5] = 32'hFFFF_FFFF;
        wmem[7] = 32'h7F7F_7F7F;
        cfg_write(0, (32'd1 << 16) | 32'd1);
        cfg_write(1, (32'd7 << 16) | 32'd5);
        chk("cfg_ifm_sel", 32'(ifm_sel), 32'd1);
        do_run(32'd1, 1, 14'd5, 14'd7, 32'hFFFF_FE04, 1'b0);
`ifdef DLA_CTRL_RELU_EN
        exp_relu = 32'd0;
`else
        exp_relu = 32'hFFFF_FE04;
`endif
        cfg_write(0, (32'd3 << 16) | 32'd1);
        do_run(32'd1, 1, 14'd5, 14'd7, exp_relu, 1'b0);

        // Address wrap across the top of the bank
        ifm0[16382] = 32'h0102_0304;
        ifm0[16383] = 32'hFF80_7F01;
        wmem[16]    = 32'h05FB_FE03;
        wmem[17]    = 32'h8080_8080;
        wmem[18]    = 32'h1122_3344;
        exp_wrap = dot4(32'h0102_0304, 32'h05FB_FE03) + dot4(32'hFF80_7F01, 32'h8080_8080)
                 + dot4(32'h0101_0101, 32'h1122_3344);
        cfg_write(0, 32'd3);
        cfg_write(1, (32'h0010 << 16) | 32'h3FFE);
        do_run(32'd1, 3, 14'h3FFE, 14'h0010, exp_wrap, 1'b0);

        // Start and CFG0 write while busy are ignored; the next run still uses len=4
        cfg_write(0, 32'd4);
        cfg_write(1, 32'd0);
        do_run(32'd1, 4, 14'd0, 14'd0, 32'd32, 1'b1);
        do_run(32'd1, 4, 14'd0, 14'd0, 32'd32, 1'b0);

        cfg_write(2, 32'd2);
        chk("clr_done", 32'(done), 32'd0);

        // Zero length, then clear-and-start in one write
        cfg_write(0, 32'd0);
        do_run(32'd1, 0, 14'd0, 14'd0, 32'd0, 1'b0);
        cfg_write(0, 32'd2);
        do_run(32'd3, 2, 14'd0, 14'd0, 32'd16, 1'b0);

        // Asynchronous reset in the middle of a len=8 run
        cfg_write(0, (32'd1 << 16) | 32'd8);
        cfg_write(1, 32'd0);
        cfg_write(2, 32'd1);
        tick();
        chk("mid_ren", 32'(sram_r_en), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_ren", 32'(sram_r_en), 32'd0);
        chk("arst_result", result, 32'd0);
        chk("arst_ifm_sel", 32'(ifm_sel), 32'd0);
        chk("arst_ifm_addr", 32'(ifm_r_addr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_ren", 32'(sram_r_en), 32'd0);
        cfg_write(0, 32'd4);
        cfg_write(1, 32'd0);
        do_run(32'd1, 4, 14'd0, 14'd0, 32'd32, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
